// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forward-select encodings and memory-wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

endpackage

// File: rtl/forward_select.sv
// One Execute-operand forward select.
// Memory-stage result wins over Writeback; x0 never forwards.
module forward_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != '0)
              && (rd_m == rs_e);
  assign hit_w = !hit_m && reg_write_w
              && (rd_w != '0) && (rd_w == rs_e);

  always_comb begin
    sel = FWD_REG;
    unique case (1'b1)
      hit_m:   sel = FWD_MEM;
      hit_w:   sel = FWD_WB;
      default: sel = FWD_REG;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard unit: forwarding, load-use stall, branch flush,
// and a memory-wait freeze FSM with timeout and stall counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemAckM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int WCW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST =
    WCW'(MEM_TIMEOUT - 1);

  mem_state_t       state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;
  logic     lw_stall;
  logic     freeze;
  logic     any_stall;

  forward_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  forward_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign lw_stall = LoadE && (RdE != '0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));

  assign freeze = (state_q != IDLE)
               || (MemReqM && !MemAckM);

  assign ForwardAE = reset ? FWD_REG : fwd_a;
  assign ForwardBE = reset ? FWD_REG : fwd_b;
  assign MemErr    = (state_q == ERR);
  assign StallCount = scnt_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (MemReqM && !MemAckM) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (MemAckM) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WLAST) begin
          state_d = ERR;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    FlushW = 1'b1;
    if (!reset) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
        FlushW = 1'b0;
      end
    end
  end

  assign any_stall = StallF || StallD
                  || StallE || StallM;

  always_comb begin
    scnt_d = scnt_q;
    if (any_stall && (scnt_q != '1))
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
// Inputs driven in the low clock phase, outputs checked 1ns later.
module tb_hazard_controller;

  localparam int AW = 5;
  localparam int TO = 15;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
  logic [AW-1:0] RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic          LoadE, PCSrcE;
  logic          MemReqM, MemAckM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          MemErr;
  logic [CW-1:0] StallCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_AW      (AW),
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .LoadE      (LoadE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemAckM    (MemAckM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr),
    .StallCount (StallCount)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // stall/flush vector: {F,D,E,M,FD,FE,FW}
  task automatic chk_ctl(input string tag,
                         input logic [6:0] exp);
    chk(tag, {25'd0, StallF, StallD, StallE, StallM,
              FlushD, FlushE, FlushW}, {25'd0, exp});
  endtask

  // close the cycle; account for the stall it contained
  task automatic next(input bit stalled);
    if (stalled) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;

    // reset: hazards present but masked
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    MemReqM = 1'b1;
    #1;
    chk_ctl("rst_ctl", 7'b0000111);
    chk("rst_fwda", ForwardAE, 2'b00);
    @(negedge clk);
    chk("rst_cnt", StallCount, 0);
    chk("rst_err", MemErr, 0);

    reset = 1'b0;
    LoadE = 1'b0; MemReqM = 1'b0;
    RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd3;
    #1;
    chk("fwd_a_mem", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    chk_ctl("idle_ctl", 7'b0000000);
    next(0);

    RdM = 5'd0; Rs2E = 5'd5;
    #1;
    chk("fwd_a_wb", ForwardAE, 2'b01);
    chk("fwd_b_wb", ForwardBE, 2'b01);
    next(0);

    RdM = 5'd5; RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    chk("fwd_a_nowr", ForwardAE, 2'b00);
    next(0);

    RdW = 5'd0; RegWriteW = 1'b1; Rs1E = 5'd0;
    #1;
    chk("fwd_a_x0", ForwardAE, 2'b00);
    RegWriteW = 1'b0;
    next(0);

    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk_ctl("lw_stall", 7'b1100010);
    next(1);

    RdE = 5'd0; Rs2D = 5'd0;
    #1;
    chk_ctl("lw_x0", 7'b0000000);
    next(0);

    RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
    #1;
    chk_ctl("lw_br", 7'b1100110);
    next(1);

    LoadE = 1'b0;
    #1;
    chk_ctl("br_only", 7'b0000110);
    PCSrcE = 1'b0;
    next(0);
    chk("cnt_pre_mem", StallCount, exp_cnt);

    // 4-cycle access, hazards must be ignored while frozen
    LoadE = 1'b1; PCSrcE = 1'b1;
    RdM = 5'd9; RegWriteM = 1'b1; Rs1E = 5'd9;
    for (int k = 0; k < 4; k++) begin
      MemReqM = 1'b1;
      MemAckM = (k == 3);
      #1;
      chk($sformatf("frz%0d", k), {25'd0, StallF,
          StallD, StallE, StallM, FlushD, FlushE,
          FlushW}, 32'b1111001);
      if (k == 1) chk("frz_fwd", ForwardAE, 2'b10);
      next(1);
    end
    MemReqM = 1'b0; MemAckM = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0;
    #1;
    chk_ctl("post_ack", 7'b0000000);
    chk("cnt_mem4", StallCount, exp_cnt);
    next(0);

    // ack on the last permitted WAIT cycle wins
    for (int k = 0; k <= TO; k++) begin
      MemReqM = 1'b1;
      MemAckM = (k == TO);
      next(1);
    end
    MemReqM = 1'b0; MemAckM = 1'b0;
    #1;
    chk("ack_wins_err", MemErr, 0);
    chk_ctl("ack_wins_ctl", 7'b0000000);
    next(0);

    // timeout with no ack
    MemReqM = 1'b1;
    for (int k = 0; k <= TO; k++) begin
      #1;
      if (k == TO) chk("to_late_err", MemErr, 0);
      next(1);
    end
    #1;
    chk("to_err", MemErr, 1);
    chk_ctl("to_ctl", 7'b1111001);
    next(1);
    MemAckM = 1'b1;
    for (int k = 0; k < 3; k++) next(1);
    #1;
    chk("err_sticky", MemErr, 1);
    chk("cnt_err", StallCount, exp_cnt);

    reset = 1'b1;
    #1;
    chk_ctl("rst2_ctl", 7'b0000111);
    @(negedge clk);
    reset = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
    #1;
    chk("rst2_err", MemErr, 0);
    chk("rst2_cnt", StallCount, 0);
    chk_ctl("rst2_idle", 7'b0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
